posit_mul_unpacked_8bit: RTL and testbench

- Two-stage pipelined multiplier for unpacked posit8 (es=0) operands.
- Sits directly upstream of the 8-bit posit encoder. It consumes two unpacked operands from the decoders and produces one unpacked result (inf/zero/sign/exp/frac/guard-sticky).
- The result drives the encoder's p_inf/p_zer/p_sgn/p_exp/p_frc/p_gs inputs without any further adjustment.
- Valid/ready handshake on both sides; full-throughput pipeline with global stall.

---
 rtl/posit_mul_unpacked_8bit.sv | 134 +++++++++++++
 tb/tb_posit_mul_unpacked_8bit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/posit_mul_unpacked_8bit.sv
// Two-stage pipelined multiplier for unpacked posit8 (es=0) operands.
// Stage 1 forms sign, exponent sum and raw product; stage 2 normalises and saturates.
module posit_mul_unpacked_8bit #(
    parameter int unsigned EXP_BIAS = 7,
    parameter int unsigned EXP_MIN  = 1,
    parameter int unsigned EXP_MAX  = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       a_inf,
    input  logic       a_zer,
    input  logic       a_sgn,
    input  logic [3:0] a_exp,
    input  logic [4:0] a_frc,
    input  logic       b_inf,
    input  logic       b_zer,
    input  logic       b_sgn,
    input  logic [3:0] b_exp,
    input  logic [4:0] b_frc,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       p_inf,
    output logic       p_zer,
    output logic       p_sgn,
    output logic [3:0] p_exp,
    output logic [4:0] p_frc,
    output logic [1:0] p_gs
);

    logic        adv;
    logic        s1_valid;
    logic        s1_inf;
    logic        s1_zer;
    logic        s1_sgn;
    logic [5:0]  s1_esum;
    logic [11:0] s1_p;

    logic [5:0]  esum_d;
    logic [11:0] prod_d;
    logic [11:0] mant_a;
    logic [11:0] mant_b;

    logic signed [6:0] t;
    logic [4:0]  frc_n;
    logic        g_n;
    logic        s_n;
    logic        inf_n;
    logic        zer_n;
    logic        sgn_n;
    logic [3:0]  exp_n;
    logic [4:0]  pfrc_n;
    logic [1:0]  gs_n;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    assign mant_a = {6'b0, 1'b1, a_frc};
    assign mant_b = {6'b0, 1'b1, b_frc};
    assign prod_d = mant_a * mant_b;
    // Wraps modulo 64; legal operands keep the sum within -12..12.
    assign esum_d = 6'({2'b00, a_exp} + {2'b00, b_exp}) - 6'(2 * EXP_BIAS);

    always_comb begin
        t = {s1_esum[5], s1_esum} + {6'b0, s1_p[11]};
        if (s1_p[11]) begin
            frc_n = s1_p[10:6];
            g_n   = s1_p[5];
            s_n   = |s1_p[4:0];
        end else begin
            frc_n = s1_p[9:5];
            g_n   = s1_p[4];
            s_n   = |s1_p[3:0];
        end

        inf_n  = 1'b0;
        zer_n  = 1'b0;
        sgn_n  = 1'b0;
        exp_n  = 4'd0;
        pfrc_n = 5'd0;
        gs_n   = 2'b00;
        if (s1_inf) begin
            inf_n = 1'b1;
        end else if (s1_zer) begin
            zer_n = 1'b1;
        end else begin
            sgn_n = s1_sgn;
            // Posits saturate to maxpos/minpos instead of overflowing.
            if (t > 7'sd6) begin
                exp_n = 4'(EXP_MAX);
            end else if (t < -7'sd6) begin
                exp_n = 4'(EXP_MIN);
            end else begin
                exp_n  = t[3:0] + 4'(EXP_BIAS);
                pfrc_n = frc_n;
                gs_n   = {g_n, s_n};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_inf    <= 1'b0;
            s1_zer    <= 1'b0;
            s1_sgn    <= 1'b0;
            s1_esum   <= 6'd0;
            s1_p      <= 12'd0;
            out_valid <= 1'b0;
            p_inf     <= 1'b0;
            p_zer     <= 1'b0;
            p_sgn     <= 1'b0;
            p_exp     <= 4'd0;
            p_frc     <= 5'd0;
            p_gs      <= 2'b00;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_inf    <= a_inf | b_inf;
            s1_zer    <= ~(a_inf | b_inf) & (a_zer | b_zer);
            s1_sgn    <= a_sgn ^ b_sgn;
            s1_esum   <= esum_d;
            s1_p      <= prod_d;
            out_valid <= s1_valid;
            p_inf     <= inf_n;
            p_zer     <= zer_n;
            p_sgn     <= sgn_n;
            p_exp     <= exp_n;
            p_frc     <= pfrc_n;
            p_gs      <= gs_n;
        end
    end

endmodule

// File: tb/tb_posit_mul_unpacked_8bit.sv
// Directed bench for posit_mul_unpacked_8bit: vector table, stall/stream and reset sequences.
module tb_posit_mul_unpacked_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       a_inf, a_zer, a_sgn;
    logic [3:0] a_exp;
    logic [4:0] a_frc;
    logic       b_inf, b_zer, b_sgn;
    logic [3:0] b_exp;
    logic [4:0] b_frc;
    logic       out_valid;
    logic       out_ready;
    logic       p_inf, p_zer, p_sgn;
    logic [3:0] p_exp;
    logic [4:0] p_frc;
    logic [1:0] p_gs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    posit_mul_unpacked_8bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_inf    (a_inf),
        .a_zer    (a_zer),
        .a_sgn    (a_sgn),
        .a_exp    (a_exp),
        .a_frc    (a_frc),
        .b_inf    (b_inf),
        .b_zer    (b_zer),
        .b_sgn    (b_sgn),
        .b_exp    (b_exp),
        .b_frc    (b_frc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p_inf    (p_inf),
        .p_zer    (p_zer),
        .p_sgn    (p_sgn),
        .p_exp    (p_exp),
        .p_frc    (p_frc),
        .p_gs     (p_gs)
    );

    // Operand: {inf, zer, sgn, exp[3:0], frc[4:0]}; result adds gs[1:0] at the bottom.
    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [13:0] r;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [13:0] result();
        return {p_inf, p_zer, p_sgn, p_exp, p_frc, p_gs};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {a_inf, a_zer, a_sgn, a_exp, a_frc} = v.a;
        {b_inf, b_zer, b_sgn, b_exp, b_frc} = v.b;
    endtask

    // Streams four vectors with out_ready held low for the first 'stall' cycles.
    task automatic run_stream(input int stall, input int base);
        int tx = 0;
        int rx = 0;
        int last_rx_cycle = -1;
        bit saw_not_ready = 0;
        for (int c = 0; c < 14; c++) begin
            out_ready = (c >= stall);
            in_valid  = (tx < 4);
            if (tx < 4) drive(vecs[base + tx]);
            #1;
            if (out_valid) begin
                if (rx < 4) begin
                    check(out_ready ? "stream_result" : "stall_stable",
                          32'(result()), 32'(vecs[base + rx].r));
                end else begin
                    check("stream_duplicate", 32'(out_valid), 32'(0));
                end
                if (out_ready) begin
                    rx++;
                    last_rx_cycle = c;
                end
            end
            if (in_valid && !in_ready) saw_not_ready = 1;
            if (in_valid && in_ready) tx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream_count", 32'(rx), 32'd4);
        if (stall == 0) begin
            check("no_bubble_in_ready", 32'(saw_not_ready), 32'd0);
            check("no_bubble_last_cycle", 32'(last_rx_cycle), 32'd5);
        end else begin
            check("stall_in_ready_drop", 32'(saw_not_ready), 32'd1);
        end
    endtask

    initial begin
        int lat;

        vecs[0]  = '{12'b0_0_0_0111_00000, 12'b0_0_0_0111_00000, 14'b0_0_0_0111_00000_00};
        vecs[1]  = '{12'b0_0_0_0111_10000, 12'b0_0_1_0111_10000, 14'b0_0_1_1000_00100_00};
        vecs[2]  = '{12'b0_0_0_0111_11111, 12'b0_0_0_0111_00001, 14'b0_0_0_1000_00000_01};
        vecs[3]  = '{12'b0_0_0_1101_00000, 12'b0_0_0_1101_00000, 14'b0_0_0_1101_00000_00};
        vecs[4]  = '{12'b0_0_0_0001_00000, 12'b0_0_0_0001_00000, 14'b0_0_0_0001_00000_00};
        vecs[5]  = '{12'b0_1_0_0000_00000, 12'b1_0_0_0000_00000, 14'b1_0_0_0000_00000_00};
        vecs[6]  = '{12'b0_0_1_0111_10000, 12'b0_0_1_0111_01000, 14'b0_0_0_0111_11100_00};
        vecs[7]  = '{12'b0_0_0_0111_00001, 12'b0_0_0_0111_10000, 14'b0_0_0_0111_10001_10};
        vecs[8]  = '{12'b0_0_0_1101_00000, 12'b0_0_0_0111_00000, 14'b0_0_0_1101_00000_00};
        vecs[9]  = '{12'b0_0_0_1101_10000, 12'b0_0_0_0111_10000, 14'b0_0_0_1101_00000_00};
        vecs[10] = '{12'b0_0_0_0001_10000, 12'b0_0_0_0111_10000, 14'b0_0_0_0010_00100_00};
        vecs[11] = '{12'b0_0_0_0001_00001, 12'b0_0_0_0001_10000, 14'b0_0_0_0001_00000_00};
        vecs[12] = '{12'b0_0_0_0001_00000, 12'b0_0_0_0110_00000, 14'b0_0_0_0001_00000_00};
        vecs[13] = '{12'b0_1_1_0111_10000, 12'b0_0_1_0111_00000, 14'b0_1_0_0000_00000_00};
        vecs[14] = '{12'b0_0_1_0111_00000, 12'b1_0_1_0000_00000, 14'b1_0_0_0000_00000_00};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_result", 32'(result()), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            check("vec_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 6) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_result", i), 32'(result()), 32'(vecs[i].r));
        end
        @(negedge clk);

        run_stream(0, 0);
        run_stream(5, 6);

        // Fill both stages, then reset: the in-flight results must vanish.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(vecs[1]);
        @(negedge clk);
        drive(vecs[2]);
        @(negedge clk);
        in_valid = 1'b0;
        check("prereset_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_result", 32'(result()), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("postreset_no_stale", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
